// File: rtl/mem_pkg.sv
// Shared types and address-map constants for the 6502 memory-side bus responder.
package mem_pkg;

  // Responder handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // One write-log record: committed RAM address and data
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } log_entry_t;

  // 17-bit so that the top of the 64 KiB space (0x10000) is representable
  localparam logic [16:0] ADDR_SPACE = 17'h10000;
  localparam logic [16:0] RAM_BASE   = 17'h00000;

  // ROM sits flush against the top of the address space
  function automatic logic [16:0] rom_base(input int rom_bytes);
    return ADDR_SPACE - 17'(rom_bytes);
  endfunction

endpackage

// File: rtl/mem_bus_responder_write_log_fifo.sv
// write_log_fifo: generic show-ahead FIFO with a sticky overflow flag.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module write_log_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("write_log_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  assign empty   = (count == {(AW + 1){1'b0}});
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot this push lands in
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign head    = mem[rd_ptr];

  // Pointer, occupancy and sticky-overflow bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW + 1){1'b0}};
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: ROM/RAM responder for the 6502 core bus with programmable
// wait states and a one-cycle ready pulse. Optional RAM write log is built when
// the macro MEM_WRITE_LOG_EN is defined.
module mem_bus_responder
  import mem_pkg::*;
#(
  parameter int RAM_BYTES   = 256,
  parameter int ROM_BYTES   = 4096,
  parameter int WAIT_STATES = 0,
  parameter int LOG_DEPTH   = 8
) (
  input  logic        ph2,
  input  logic        resetb,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic        bus_err,
  input  logic        log_rd_en,
  output logic [23:0] log_rdata,
  output logic        log_empty,
  output logic        log_ovf
);

  localparam int              RAM_AW       = $clog2(RAM_BYTES);
  localparam int              ROM_AW       = $clog2(ROM_BYTES);
  localparam logic [16:0]     RAM_LIMIT    = RAM_BASE + 17'(RAM_BYTES);
  localparam logic [16:0]     ROM_BASE     = rom_base(ROM_BYTES);
  localparam logic [ROM_AW-1:0] ROM_BASE_IDX = ROM_BASE[ROM_AW-1:0];
  localparam logic [3:0]      WAIT_LOAD    = 4'(WAIT_STATES);

  if (RAM_BYTES + ROM_BYTES > 65536) begin : g_bad_map
    $error("mem_bus_responder: RAM and ROM regions overlap");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("mem_bus_responder: WAIT_STATES must be 0..15");
  end
  if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_log
    $error("mem_bus_responder: LOG_DEPTH must be a power of two >= 2");
  end

  // Memory arrays; never cleared by reset, ROM is loaded from outside
  logic [7:0] ram [RAM_BYTES];
  logic [7:0] rom [ROM_BYTES];

  resp_state_t state;
  resp_state_t state_next;
  logic [3:0]  count;
  logic [3:0]  count_next;
  logic        load_req;
  logic        resp_enter;

  logic [15:0] lat_addr;
  logic        lat_we;
  logic [7:0]  lat_wdata;

  logic              ram_hit;
  logic              rom_hit;
  logic              unmapped;
  logic [RAM_AW-1:0] ram_idx;
  logic [ROM_AW-1:0] rom_idx;
  logic [7:0]        rd_value;
  logic              commit_ram;

  // Decode always works on the captured address, never the live bus
  assign ram_hit    = ({1'b0, lat_addr} < RAM_LIMIT);
  assign rom_hit    = ({1'b0, lat_addr} >= ROM_BASE);
  assign unmapped   = ~ram_hit & ~rom_hit;
  assign ram_idx    = lat_addr[RAM_AW-1:0];
  assign rom_idx    = lat_addr[ROM_AW-1:0] - ROM_BASE_IDX;
  assign commit_ram = resp_enter & lat_we & ram_hit & resetb;

  // FSM state, wait counter and request capture registers
  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      count     <= 4'd0;
      lat_addr  <= 16'h0000;
      lat_we    <= 1'b0;
      lat_wdata <= 8'h00;
    end else begin
      state <= state_next;
      count <= count_next;
      if (load_req) begin
        lat_addr  <= addr;
        lat_we    <= we;
        lat_wdata <= wdata;
      end
    end
  end

  // Next-state logic: capture, count down wait states, abort on dropped req
  always_comb begin
    state_next = state;
    count_next = count;
    load_req   = 1'b0;
    resp_enter = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = WAIT;
          count_next = WAIT_LOAD;
          load_req   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (!req) begin
          state_next = IDLE;
        end else if (count == 4'd0) begin
          state_next = RESP;
          resp_enter = 1'b1;
        end else begin
          count_next = count - 4'd1;
        end
      end
      // req may still be high here; it is not treated as a new request
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read mux: RAM, ROM, or all-ones for unmapped space
  always_comb begin
    rd_value = 8'hFF;
    if (ram_hit) begin
      rd_value = ram[ram_idx];
    end else if (rom_hit) begin
      rd_value = rom[rom_idx];
    end else begin
      rd_value = 8'hFF;
    end
  end

  // Registered response outputs, valid in the single RESP cycle
  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      ready   <= 1'b0;
      bus_err <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      ready   <= resp_enter;
      bus_err <= resp_enter & (unmapped | (lat_we & rom_hit));
      if (resp_enter) begin
        rdata <= lat_we ? 8'h00 : rd_value;
      end else begin
        rdata <= rdata;
      end
    end
  end

  // RAM write port, committed on the edge that enters RESP
  always_ff @(posedge ph2) begin
    if (commit_ram) ram[ram_idx] <= lat_wdata;
  end

`ifdef MEM_WRITE_LOG_EN
  log_entry_t log_in;
  logic       unused_log_full;

  assign log_in.addr = lat_addr;
  assign log_in.data = lat_wdata;

  write_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH ($bits(log_entry_t))
  ) u_write_log (
    .clk       (ph2),
    .rst_n     (resetb),
    .push      (commit_ram),
    .push_data (log_in),
    .pop       (log_rd_en),
    .head      (log_rdata),
    .empty     (log_empty),
    .full      (unused_log_full),
    .ovf       (log_ovf)
  );
`else
  logic unused_log_rd_en;

  assign unused_log_rd_en = log_rd_en;
  assign log_rdata        = 24'h000000;
  assign log_empty        = 1'b1;
  assign log_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with no wait states and
// one with three, ROM preloaded hierarchically, RAM preloaded over the bus.
module tb_mem_bus_responder;
  import mem_pkg::*;

  logic ph2 = 1'b0;
  logic resetb;

  logic        req0, we0, ready0, bus_err0, log_rd_en0, log_empty0, log_ovf0;
  logic [15:0] addr0;
  logic [7:0]  wdata0, rdata0;
  logic [23:0] log_rdata0;

  logic        req3, we3, ready3, bus_err3, log_rd_en3, log_empty3, log_ovf3;
  logic [15:0] addr3;
  logic [7:0]  wdata3, rdata3;
  logic [23:0] log_rdata3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 ph2 = ~ph2;

  mem_bus_responder #(.WAIT_STATES(0)) dut0 (
    .ph2(ph2), .resetb(resetb), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .bus_err(bus_err0), .log_rd_en(log_rd_en0),
    .log_rdata(log_rdata0), .log_empty(log_empty0), .log_ovf(log_ovf0)
  );

  mem_bus_responder #(.WAIT_STATES(3)) dut3 (
    .ph2(ph2), .resetb(resetb), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .rdata(rdata3), .ready(ready3), .bus_err(bus_err3), .log_rd_en(log_rd_en3),
    .log_rdata(log_rdata3), .log_empty(log_empty3), .log_ovf(log_ovf3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [15:0] a, input logic [7:0] d);
    if (sel == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req3 = r; we3 = w; addr3 = a; wdata3 = d;
    end
  endtask

  // One full transaction; lat counts posedges from the one that samples req
  task automatic xfer(input int sel, input logic w, input logic [15:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic err, output int lat);
    logic got;
    got = 1'b0; rd = 8'h00; err = 1'b0; lat = 0;
    @(negedge ph2);
    drive(sel, 1'b1, w, a, d);
    for (int i = 1; i <= 24; i++) begin
      @(posedge ph2); #1;
      if ((sel == 0) ? ready0 : ready3) begin
        got = 1'b1;
        lat = i;
        rd  = (sel == 0) ? rdata0 : rdata3;
        err = (sel == 0) ? bus_err0 : bus_err3;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, 16'h0000, 8'h00);
    check_eq("xfer_done", 32'(got), 32'd1);
    @(posedge ph2); #1;
  endtask

  // Watch for any ready pulse over a number of cycles
  task automatic watch_ready(input int sel, input int cycles, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge ph2); #1;
      if ((sel == 0) ? ready0 : ready3) seen = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;
    int         lat;
    logic       seen;

    resetb = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(3, 1'b0, 1'b0, 16'h0000, 8'h00);
    log_rd_en0 = 1'b0;
    log_rd_en3 = 1'b0;

    dut0.rom[4092] = 8'h00;
    dut0.rom[4093] = 8'hF0;
    dut0.rom[16]   = 8'h3C;
    dut3.rom[0]    = 8'hA5;

    repeat (3) @(posedge ph2);
    #1;
    check_eq("rst_ready",   32'(ready0),    32'd0);
    check_eq("rst_bus_err", 32'(bus_err0),  32'd0);
    check_eq("rst_rdata",   32'(rdata0),    32'h00);
    check_eq("rst_state",   32'(dut0.state), 32'(IDLE));
    check_eq("rst_count",   32'(dut3.count), 32'd0);
    check_eq("rst_log_empty", 32'(log_empty0), 32'd1);
    check_eq("rst_log_ovf",   32'(log_ovf0),   32'd0);
    @(negedge ph2);
    resetb = 1'b1;

    // Reset vector fetch from the top of ROM
    xfer(0, 1'b0, 16'hFFFC, 8'h00, rd, err, lat);
    check_eq("vec_lo_data", 32'(rd), 32'h00);
    check_eq("vec_lo_err",  32'(err), 32'd0);
    check_eq("vec_lo_lat",  32'(lat), 32'd2);
    xfer(0, 1'b0, 16'hFFFD, 8'h00, rd, err, lat);
    check_eq("vec_hi_data", 32'(rd), 32'hF0);
    check_eq("vec_hi_lat",  32'(lat), 32'd2);

    // RAM write then read back
    xfer(0, 1'b1, 16'h0030, 8'hCE, rd, err, lat);
    check_eq("wr30_err", 32'(err), 32'd0);
    check_eq("wr30_lat", 32'(lat), 32'd2);
    check_eq("ram48",    32'(dut0.ram[48]), 32'hCE);
    xfer(0, 1'b0, 16'h0030, 8'h00, rd, err, lat);
    check_eq("rd30_data", 32'(rd), 32'hCE);

    // RAM/unmapped boundary
    xfer(0, 1'b1, 16'h00FF, 8'h9A, rd, err, lat);
    xfer(0, 1'b0, 16'h00FF, 8'h00, rd, err, lat);
    check_eq("rdFF_data", 32'(rd), 32'h9A);
    check_eq("rdFF_err",  32'(err), 32'd0);
    xfer(0, 1'b0, 16'h0100, 8'h00, rd, err, lat);
    check_eq("rd100_data", 32'(rd), 32'hFF);
    check_eq("rd100_err",  32'(err), 32'd1);
    xfer(0, 1'b0, 16'hEFFF, 8'h00, rd, err, lat);
    check_eq("rdEFFF_err", 32'(err), 32'd1);

    // Three wait states: latency, then an aborted request
    xfer(3, 1'b0, 16'hF000, 8'h00, rd, err, lat);
    check_eq("ws3_lat",  32'(lat), 32'd5);
    check_eq("ws3_data", 32'(rd),  32'hA5);
    check_eq("ws3_err",  32'(err), 32'd0);
    @(negedge ph2);
    drive(3, 1'b1, 1'b0, 16'hF000, 8'h00);
    @(posedge ph2); #1;
    drive(3, 1'b0, 1'b0, 16'h0000, 8'h00);
    watch_ready(3, 8, seen);
    check_eq("abort_no_ready", 32'(seen), 32'd0);
    check_eq("abort_state",    32'(dut3.state), 32'(IDLE));

    // Unmapped read and write to ROM
    xfer(0, 1'b0, 16'h4000, 8'h00, rd, err, lat);
    check_eq("rd4000_data", 32'(rd),  32'hFF);
    check_eq("rd4000_err",  32'(err), 32'd1);
    xfer(0, 1'b1, 16'hF010, 8'h55, rd, err, lat);
    check_eq("wrrom_err", 32'(err), 32'd1);
    check_eq("wrrom_keep", 32'(dut0.rom[16]), 32'h3C);
    xfer(0, 1'b0, 16'hF010, 8'h00, rd, err, lat);
    check_eq("rdrom_data", 32'(rd),  32'h3C);
    check_eq("rdrom_err",  32'(err), 32'd0);

    // Reset in the middle of a write's wait period
    xfer(3, 1'b1, 16'h0010, 8'h11, rd, err, lat);
    check_eq("pre_ram16", 32'(dut3.ram[16]), 32'h11);
    @(negedge ph2);
    drive(3, 1'b1, 1'b1, 16'h0010, 8'h77);
    @(posedge ph2); #1;
    @(posedge ph2); #1;
    resetb = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(ready3), 32'd0);
    check_eq("midrst_state", 32'(dut3.state), 32'(IDLE));
    @(negedge ph2);
    resetb = 1'b1;
    drive(3, 1'b0, 1'b0, 16'h0000, 8'h00);
    watch_ready(3, 8, seen);
    check_eq("midrst_no_ready", 32'(seen), 32'd0);
    check_eq("midrst_ram16", 32'(dut3.ram[16]), 32'h11);
    xfer(3, 1'b0, 16'h0010, 8'h00, rd, err, lat);
    check_eq("midrst_rd16", 32'(rd), 32'h11);

`ifdef MEM_WRITE_LOG_EN
    // Fresh log, nine writes into an eight-deep log
    @(negedge ph2);
    resetb = 1'b0;
    @(negedge ph2);
    resetb = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        check_eq("log_ovf_before", 32'(log_ovf0), 32'd0);
      end
      xfer(0, 1'b1, 16'h0020 + 16'(i), 8'h40 + 8'(i), rd, err, lat);
    end
    check_eq("log_ovf_set",  32'(log_ovf0),  32'd1);
    check_eq("log_nonempty", 32'(log_empty0), 32'd0);
    check_eq("log_head0",    32'(log_rdata0), 32'h002040);
    @(negedge ph2); log_rd_en0 = 1'b1;
    @(negedge ph2); log_rd_en0 = 1'b0;
    check_eq("log_head1", 32'(log_rdata0), 32'h002141);
    for (int i = 0; i < 7; i++) begin
      @(negedge ph2); log_rd_en0 = 1'b1;
      @(negedge ph2); log_rd_en0 = 1'b0;
    end
    check_eq("log_empty_end", 32'(log_empty0), 32'd1);
    check_eq("log_ovf_sticky", 32'(log_ovf0), 32'd1);
`else
    // Log disabled: pops ignored, outputs tied
    @(negedge ph2); log_rd_en0 = 1'b1;
    @(negedge ph2); log_rd_en0 = 1'b0;
    check_eq("nolog_empty", 32'(log_empty0), 32'd1);
    check_eq("nolog_ovf",   32'(log_ovf0),   32'd0);
    check_eq("nolog_rdata", 32'(log_rdata0), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
